// File: rtl/lsu_rmw_pkg.sv
// Shared types for the lsu_rmw load/store initiator: access sizes and FSM states.
package lsu_rmw_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    RSP
  } state_t;

  // Illegal size or an address not aligned to the access size.
  function automatic logic is_bad(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = lo[0];
      SIZE_W:  bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane steering: extended load value and merged store word from one memory word.
module lsu_lane
  import lsu_rmw_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  input  logic [1:0]       addr,
  input  logic [1:0]       size,
  input  logic             uns,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] ldata,
  output logic [WIDTH-1:0] mdata
);

  logic [7:0]  bsel;
  logic [15:0] hsel;

  always_comb begin
    bsel  = word[{addr, 3'b000} +: 8];
    hsel  = word[{addr[1], 4'b0000} +: 16];
    ldata = word;
    mdata = wdata;
    case (size)
      SIZE_B: begin
        ldata = {{(WIDTH-8){bsel[7] & ~uns}}, bsel};
        mdata = word;
        mdata[{addr, 3'b000} +: 8] = wdata[7:0];
      end
      SIZE_H: begin
        ldata = {{(WIDTH-16){hsel[15] & ~uns}}, hsel};
        mdata = word;
        mdata[{addr[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        ldata = word;
        mdata = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store initiator: byte/half/word accesses on a word-only memory, with
// read-modify-write for sub-word stores. All outputs come straight from flops.
module lsu_rmw
  import lsu_rmw_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             mem_ren,
  output logic [WIDTH-1:0] mem_raddr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_wen,
  output logic [WIDTH-1:0] mem_waddr,
  output logic [WIDTH-1:0] mem_wdata
);

  state_t           state, state_nxt;
  logic             accept, bad;
  logic [1:0]       a_lo, a_size;
  logic             a_we, a_uns;
  logic [WIDTH-1:0] a_wdata;
  logic [WIDTH-1:0] lane_ldata, lane_mdata;
  logic             ren_d, wen_d, valid_d, ready_d;

  assign accept = req_valid && req_ready;
  assign bad    = is_bad(req_size, req_addr[1:0]);

  lsu_lane #(.WIDTH(WIDTH)) u_lane (
    .word  (mem_rdata),
    .addr  (a_lo),
    .size  (a_size),
    .uns   (a_uns),
    .wdata (a_wdata),
    .ldata (lane_ldata),
    .mdata (lane_mdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bad)                             state_nxt = RSP;
          else if (req_we && req_size == SIZE_W) state_nxt = WR;
          else                                 state_nxt = RD;
        end
      end
      RD:      state_nxt = CAP;
      CAP:     state_nxt = a_we ? WR : RSP;
      WR:      state_nxt = RSP;
      RSP:     state_nxt = rsp_ready ? IDLE : RSP;
      default: state_nxt = IDLE;
    endcase
  end

  // Control outputs are registered from the next state so each strobe lines up with its state.
  always_comb begin
    ren_d   = (state_nxt == RD);
    wen_d   = (state_nxt == WR);
    valid_d = (state_nxt == RSP);
    ready_d = (state_nxt == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_ren   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_raddr <= '0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      a_lo      <= '0;
      a_size    <= '0;
      a_we      <= 1'b0;
      a_uns     <= 1'b0;
      a_wdata   <= '0;
    end else begin
      req_ready <= ready_d;
      rsp_valid <= valid_d;
      mem_ren   <= ren_d;
      mem_wen   <= wen_d;
      if (accept) begin
        a_lo      <= req_addr[1:0];
        a_size    <= req_size;
        a_we      <= req_we;
        a_uns     <= req_unsigned;
        a_wdata   <= req_wdata;
        mem_raddr <= {req_addr[WIDTH-1:2], 2'b00};
        mem_waddr <= {req_addr[WIDTH-1:2], 2'b00};
        mem_wdata <= req_wdata;
        rsp_rdata <= '0;
        rsp_err   <= bad;
      end
      if (state == CAP) begin
        if (a_we) mem_wdata <= lane_mdata;
        else      rsp_rdata <= lane_ldata;
      end
    end
  end

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a word-array memory and a transaction-level reference model.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;

  lsu_rmw #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory device seen by the DUT
  logic [31:0] dev_mem [int];
  int n_ren = 0, n_wen = 0;

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    int idx = int'(a / 4);
    return dev_mem.exists(idx) ? dev_mem[idx] : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (mem_ren) begin
      mem_rdata <= dev_rd(mem_raddr);
      n_ren++;
    end
    if (mem_wen) begin
      dev_mem[int'(mem_waddr / 4)] = mem_wdata;
      n_wen++;
    end
  end

  // Reference model: one outstanding transaction, expectations in cycles after accept
  logic [31:0] mmem [int];
  bit          active = 0;
  int          acc_t, ren_cyc, wen_cyc, rsp_cyc;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic        e_err;
  bit          seen;
  int          obs_lat;
  logic [31:0] obs_rdata;
  logic        obs_err;

  task automatic model_accept(input int t);
    int          idx, off, nb;
    logic [31:0] w;
    longint unsigned m, v;
    idx = int'(req_addr / 4);
    off = int'(req_addr % 4);
    nb  = 1 << req_size;
    w   = mmem.exists(idx) ? mmem[idx] : 32'h0;
    m   = (64'd1 << (8 * nb)) - 64'd1;
    acc_t = t; seen = 0; obs_lat = -1;
    e_addr = req_addr - req_addr % 4;
    e_rdata = 0; e_wdata = 0;
    ren_cyc = -1; wen_cyc = -1;
    e_err = (req_size == 2'd3) || (req_size == 2'd1 && req_addr % 2 != 0) ||
            (req_size == 2'd2 && req_addr % 4 != 0);
    if (e_err) begin
      rsp_cyc = t + 1;
    end else if (req_we && nb == 4) begin
      wen_cyc = t + 1; rsp_cyc = t + 2; e_wdata = req_wdata;
    end else if (req_we) begin
      ren_cyc = t + 1; wen_cyc = t + 3; rsp_cyc = t + 4;
      v = ({32'h0, w} & ~(m << (8 * off))) | (({32'h0, req_wdata} & m) << (8 * off));
      e_wdata = v[31:0];
    end else begin
      ren_cyc = t + 1; rsp_cyc = t + 3;
      v = ({32'h0, w} >> (8 * off)) & m;
      if (!req_unsigned && ((v >> (8 * nb - 1)) & 64'd1) == 64'd1) v = v | ~m;
      e_rdata = v[31:0];
    end
    active = 1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      active = 0;
    end else begin
      if (active && cyc >= rsp_cyc && rsp_ready) active = 0;
      else if (!active && req_valid) model_accept(cyc);
      cyc = cyc + 1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      bit ev, ew, evld;
      ev   = active && cyc == ren_cyc;
      ew   = active && cyc == wen_cyc;
      evld = active && cyc >= rsp_cyc;
      chk("mem_ren", {31'h0, mem_ren}, {31'h0, ev});
      chk("mem_wen", {31'h0, mem_wen}, {31'h0, ew});
      chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, evld});
      chk("req_ready", {31'h0, req_ready}, {31'h0, !active});
      if (ev) chk("mem_raddr", mem_raddr, e_addr);
      if (ew) begin
        chk("mem_waddr", mem_waddr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        mmem[int'(e_addr / 4)] = e_wdata;
      end
      if (evld) begin
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, e_err});
      end
      if (active && rsp_valid && !seen) begin
        seen = 1; obs_lat = cyc - acc_t; obs_rdata = rsp_rdata; obs_err = rsp_err;
      end
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    dev_mem[int'(a / 4)] = d;
    mmem[int'(a / 4)] = d;
  endtask

  task automatic start_req(input logic we, input logic [1:0] sz, input logic un,
                           input logic [31:0] a, input logic [31:0] wd);
    int k = 0;
    while (active && k < 50) begin @(negedge clk); k++; end
    chk("idle_before_req", {31'h0, active}, 32'h0);
    active = 0;
    req_we = we; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
    req_valid = 1;
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic wait_rsp(input string nm, input int lat, input logic [31:0] rd, input logic er);
    int k = 0;
    while (active && k < 60) begin @(negedge clk); k++; end
    chk({nm, "_timeout"}, {31'h0, active}, 32'h0);
    active = 0;
    chk({nm, "_lat"}, 32'(obs_lat), 32'(lat));
    chk({nm, "_rdata"}, obs_rdata, rd);
    chk({nm, "_err"}, {31'h0, obs_err}, {31'h0, er});
  endtask

  task automatic xfer(input string nm, input logic we, input logic [1:0] sz, input logic un,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int lat, input logic [31:0] rd, input logic er);
    start_req(we, sz, un, a, wd);
    wait_rsp(nm, lat, rd, er);
  endtask

  initial begin
    int r0, w0;
    rst = 1; rsp_ready = 1; req_valid = 0; req_we = 0; req_size = 0;
    req_unsigned = 0; req_addr = 0; req_wdata = 0; mem_rdata = 0;
    #1;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_mem_ren", {31'h0, mem_ren}, 32'h0);
    chk("rst_mem_wen", {31'h0, mem_wen}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    preload(32'h20, 32'h11223344);
    preload(32'h30, 32'h80FF7F01);
    preload(32'h40, 32'hCAFEF00D);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);

    xfer("sw10", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 0);
    chk("mem10", dev_rd(32'h10), 32'hDEADBEEF);
    xfer("lw10", 0, 2'b10, 0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 0);

    r0 = n_ren; w0 = n_wen;
    xfer("sb22", 1, 2'b00, 0, 32'h22, 32'h000000AA, 4, 32'h0, 0);
    chk("sb22_nren", 32'(n_ren - r0), 32'd1);
    chk("sb22_nwen", 32'(n_wen - w0), 32'd1);
    chk("mem20", dev_rd(32'h20), 32'h11AA3344);

    xfer("sh12", 1, 2'b01, 0, 32'h12, 32'h00001234, 4, 32'h0, 0);
    xfer("lw10b", 0, 2'b10, 0, 32'h10, 32'h0, 3, 32'h1234BEEF, 0);

    xfer("lb31", 0, 2'b00, 0, 32'h31, 32'h0, 3, 32'h0000007F, 0);
    xfer("lb32", 0, 2'b00, 0, 32'h32, 32'h0, 3, 32'hFFFFFFFF, 0);
    xfer("lbu32", 0, 2'b00, 1, 32'h32, 32'h0, 3, 32'h000000FF, 0);
    xfer("lh32", 0, 2'b01, 0, 32'h32, 32'h0, 3, 32'hFFFF80FF, 0);
    xfer("lhu30", 0, 2'b01, 1, 32'h30, 32'h0, 3, 32'h00007F01, 0);

    r0 = n_ren; w0 = n_wen;
    xfer("lh01", 0, 2'b01, 0, 32'h01, 32'h0, 1, 32'h0, 1);
    xfer("sw02", 1, 2'b10, 0, 32'h02, 32'h12345678, 1, 32'h0, 1);
    xfer("sz11", 0, 2'b11, 0, 32'h30, 32'h0, 1, 32'h0, 1);
    chk("err_nren", 32'(n_ren - r0), 32'd0);
    chk("err_nwen", 32'(n_wen - w0), 32'd0);

    rsp_ready = 0;
    start_req(0, 2'b10, 0, 32'h30, 32'h0);
    repeat (7) @(negedge clk);
    chk("bp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("bp_rdata", rsp_rdata, 32'h80FF7F01);
    chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
    rsp_ready = 1;
    @(negedge clk);
    chk("bp_ready_after", {31'h0, req_ready}, 32'h1);
    wait_rsp("bp", 3, 32'h80FF7F01, 0);

    w0 = n_wen;
    start_req(1, 2'b00, 0, 32'h41, 32'h00000055);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("ar_mem_wen", {31'h0, mem_wen}, 32'h0);
    chk("ar_mem_ren", {31'h0, mem_ren}, 32'h0);
    chk("ar_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("ar_req_ready", {31'h0, req_ready}, 32'h1);
    chk("ar_mem_wdata", mem_wdata, 32'h0);
    chk("ar_mem_raddr", mem_raddr, 32'h0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (6) @(negedge clk);
    chk("ar_nwen", 32'(n_wen - w0), 32'd0);
    chk("mem40", dev_rd(32'h40), 32'hCAFEF00D);
    xfer("lw40", 0, 2'b10, 0, 32'h40, 32'h0, 3, 32'hCAFEF00D, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store initiator that drives the data memory block's request side: read port A (rena/addra/outa) and write port 1 (wen1/addrw1/dataw1).
- Accepts byte, half and word loads/stores from the core over a valid/ready handshake.
- Stores narrower than a word are done as read-modify-write, because the memory has word-wide writes with no byte enables.
- Returns sign- or zero-extended load data, or a misalignment error, on a valid/ready response channel.

Parameters:
- WIDTH, 32, data and address width; fixed at 32 (lane logic assumes 4 bytes per word).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  core request valid
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0
- req_addr  in  WIDTH  byte address
- req_wdata  in  WIDTH  store data; the value sits in the low bits
- rsp_valid  out  1  response valid
- rsp_ready  in  1  core accepts the response
- rsp_rdata  out  WIDTH  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal size
- mem_ren  out  1  to rena
- mem_raddr  out  WIDTH  to addra; word aligned ({addr[31:2],2'b00})
- mem_rdata  in  WIDTH  from outa
- mem_wen  out  1  to wen1
- mem_waddr  out  WIDTH  to addrw1; word aligned
- mem_wdata  out  WIDTH  to dataw1

Behaviour:
Reset and output timing
- All outputs are registered.
- On rst: state returns to IDLE. rsp_valid, rsp_err, mem_ren and mem_wen go to 0 immediately (asynchronously). All data and address outputs reset to 0.
- Reset mid-operation aborts the transaction. No write is issued after reset is released.

Memory read timing
- Read latency is 1: mem_rdata is valid in the cycle after the cycle in which mem_ren was high.

Handshake
- A request is accepted on a rising edge with req_valid && req_ready.
- The accepted address, data, size, we and unsigned values are latched at that edge.
- While rsp_valid=1 and rsp_ready=0, rsp_rdata and rsp_err hold stable.
- Exactly one response is produced per accepted request.

States
- IDLE: req_ready=1. On accept:
  - illegal size or misaligned address -> RSP with rsp_err=1
  - word store -> WR
  - any other request -> RD
- RD: mem_ren=1 for exactly one cycle -> CAP.
- CAP: mem_rdata is registered at the edge.
  - Load: extract the lane, extend, load rsp_rdata -> RSP.
  - Sub-word store: build the merged word -> WR.
- WR: mem_wen=1 for exactly one cycle with the merged or full word -> RSP.
- RSP: rsp_valid=1. On rsp_ready -> IDLE.
- No new request is accepted in the cycle rsp_ready is seen; req_ready rises on the next cycle.

Alignment rules
- Half is misaligned when addr[0]=1.
- Word is misaligned when addr[1:0]!=0.
- A misaligned or illegal-size request produces no memory activity.

Lane rules (little-endian)
- Byte lane = addr[1:0]; the lane's data is mem_rdata[8*lane+7 : 8*lane].
- Half lane = addr[1]; the lane's data is mem_rdata[16*addr[1]+15 : 16*addr[1]].
- Sign extension copies the lane's MSB.
- Store merge replaces only the addressed lane with req_wdata[7:0] (byte) or req_wdata[15:0] (half).

Latency (T = accept edge; the response cycle is the first cycle with rsp_valid=1)
- Error: response in T+1.
- Word store: mem_wen high in T+1; response in T+2.
- Load: mem_ren high in T+1; response in T+3.
- Sub-word store: mem_ren high in T+1, mem_wen high in T+3; response in T+4.

Decomposition:
- Shared package holds:
  - SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10
  - state encodings IDLE, RD, CAP, WR, RSP
- One combinational sub-module, lsu_lane: given word, addr[1:0], size, unsigned and wdata, it produces both the extended load value and the merged store word.
- The FSM and registers stay in lsu_rmw.

Test Plan:
- Word store then word load:
  - Store 0xDEADBEEF @0x10 -> mem_wen pulse with waddr 0x10, wdata 0xDEADBEEF; response in T+2 with err=0.
  - Load @0x10 -> rsp_rdata 0xDEADBEEF in T+3.
- Byte store RMW: memory word 0x11223344 @0x20; store byte 0xAA @0x22 -> one mem_ren (raddr 0x20), then one mem_wen with wdata 0x11AA3344; response in T+4.
- Signed and unsigned loads of word 0x80FF7F01 @0x30:
  - lb @0x31 -> 0x0000007F
  - lb @0x32 -> 0xFFFFFFFF
  - lbu @0x32 -> 0x000000FF
  - lh @0x32 -> 0xFFFF80FF
  - lhu @0x30 -> 0x00007F01
- Misaligned and illegal requests: lh @0x01, sw @0x02, size=11 -> rsp_err=1, rsp_rdata=0 in T+1; mem_ren and mem_wen stay 0 throughout.
- Response backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stay stable, req_ready stays 0; after rsp_ready=1 is seen, req_ready=1 on the next cycle.
- Reset mid-RMW: assert rst during CAP of a byte store -> mem_wen stays 0, outputs are 0 immediately, state is IDLE; memory content is unchanged.
